// File: rtl/portable_status_pkg.sv
// Shared definitions for the portable shell status controller: LED mode field
// width and the per-channel mode encoding.
package portable_status_pkg;

  localparam int LED_MODE_W = 3;

  typedef enum logic [LED_MODE_W-1:0] {
    MODE_OFF        = 3'd0,
    MODE_ON         = 3'd1,
    MODE_FOLLOW     = 3'd2,
    MODE_TOGGLE     = 3'd3,
    MODE_BLINK      = 3'd4,
    MODE_STRETCH    = 3'd5,
    MODE_INV_FOLLOW = 3'd6
  } led_mode_e;

endpackage

// File: rtl/portable_led_channel.sv
// One status LED channel: source synchroniser, rise detect, toggle and
// pulse-stretch state, and the registered mode mux driving the pin.
module portable_led_channel
  import portable_status_pkg::*;
#(
  parameter int STRETCH_TICKS = 50
) (
  input  logic                  clock_in,
  input  logic                  reset_n,
  input  logic                  core_reset,
  input  logic                  tick,
  input  logic                  blink_phase,
  input  logic                  src,
  input  logic [LED_MODE_W-1:0] mode,
  output logic                  led
);

  localparam int SW = $clog2(STRETCH_TICKS + 1);
  localparam logic [SW-1:0] STRETCH_LOAD = SW'(STRETCH_TICKS);

  logic          s1, s2, s3;
  logic          rise;
  logic          toggle_q;
  logic [SW-1:0] stretch_cnt;
  logic          led_nxt;

  // A rise reloads even on a tick cycle; otherwise count down on ticks and hold at zero.
  function automatic logic [SW-1:0] stretch_next(input logic [SW-1:0] cnt,
                                                 input logic          rise_i,
                                                 input logic          tick_i);
    if (rise_i)
      return STRETCH_LOAD;
    else if (tick_i && (cnt != '0))
      return cnt - 1'b1;
    else
      return cnt;
  endfunction

  assign rise = s2 & ~s3;

  // Synchroniser keeps running through core_reset so the edge detector is primed.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= src;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      toggle_q    <= 1'b0;
      stretch_cnt <= '0;
    end else if (core_reset) begin
      toggle_q    <= 1'b0;
      stretch_cnt <= '0;
    end else begin
      if (rise)
        toggle_q <= ~toggle_q;
      stretch_cnt <= stretch_next(stretch_cnt, rise, tick);
    end
  end

  always_comb begin
    led_nxt = 1'b0;
    case (mode)
      MODE_ON:         led_nxt = 1'b1;
      MODE_FOLLOW:     led_nxt = s2;
      MODE_TOGGLE:     led_nxt = toggle_q;
      MODE_BLINK:      led_nxt = blink_phase;
      MODE_STRETCH:    led_nxt = (stretch_cnt != '0);
      MODE_INV_FOLLOW: led_nxt = ~s2;
      default:         led_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n)
      led <= 1'b0;
    else if (core_reset)
      led <= 1'b0;
    else
      led <= led_nxt;
  end

endmodule

// File: rtl/portable_status_ctrl.sv
// Board-support controller for the portable shells: stretched power-on/soft
// reset for the core, a prescaled tick/blink timebase and NUM_LED status LEDs.
module portable_status_ctrl
  import portable_status_pkg::*;
#(
  parameter int NUM_LED       = 5,
  parameter int POR_CYCLES    = 256,
  parameter int TICK_DIV      = 1000000,
  parameter int STRETCH_TICKS = 50
) (
  input  logic                          clock_in,
  input  logic                          reset_n,
  input  logic                          soft_rst_req,
  input  logic [LED_MODE_W*NUM_LED-1:0] led_mode,
  input  logic [NUM_LED-1:0]            led_src,
  output logic                          core_reset,
  output logic                          tick,
  output logic [NUM_LED-1:0]            led_out
);

  localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic             soft_prev;
  logic             soft_rise;
  logic [POR_W-1:0] por_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             blink_phase;

  assign soft_rise = soft_rst_req & ~soft_prev;

  // A soft request restarts the sequence from zero even if one is already running.
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      soft_prev  <= 1'b0;
      core_reset <= 1'b1;
      por_cnt    <= '0;
    end else begin
      soft_prev <= soft_rst_req;
      if (soft_rise) begin
        core_reset <= 1'b1;
        por_cnt    <= '0;
      end else if (core_reset) begin
        if (por_cnt == POR_LAST) begin
          core_reset <= 1'b0;
          por_cnt    <= '0;
        end else begin
          por_cnt <= por_cnt + 1'b1;
        end
      end
    end
  end

  assign tick = ~core_reset & (div_cnt == DIV_LAST);

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (core_reset) begin
      div_cnt     <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      div_cnt     <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LED; i++) begin : g_led
    portable_led_channel #(
      .STRETCH_TICKS(STRETCH_TICKS)
    ) u_chan (
      .clock_in   (clock_in),
      .reset_n    (reset_n),
      .core_reset (core_reset),
      .tick       (tick),
      .blink_phase(blink_phase),
      .src        (led_src[i]),
      .mode       (led_mode[LED_MODE_W*i +: LED_MODE_W]),
      .led        (led_out[i])
    );
  end

endmodule
